// File: rtl/frontend_read_return_serializer.sv
// Purpose: buffers wide backend read-return words (data, request ID, core number,
// start beat) in a DEPTH-entry FIFO and streams each one to the interconnection
// as BEATS frontend beats. With CRITICAL_FIRST=1 the beats start at the requested
// beat and wrap around; with CRITICAL_FIRST=0 they always go 0 upward.
//
// Ports:
//   i_clk, i_rst_n               clock (rising edge), async active-low reset
//   o_frontend_receive_ready     FIFO has a free entry
//   i_returned_data_valid        backend word valid
//   i_returned_data              backend word, beat k = bits [k*FWS +: FWS]
//   i_returned_request_id        request tag of the word
//   i_returned_core_num          destination core of the word
//   i_returned_start_beat        critical beat index
//   i_interconnection_ready      downstream accepts the current beat
//   o_scheduler_request_valid    beat valid
//   o_scheduler_read_data        current beat
//   o_scheduler_read_data_last   final beat of the word
//   o_scheduler_request_id       head entry request ID
//   o_scheduler_core_num         head entry core number
//   o_beat_index                 index of the current beat inside the word
//   o_fifo_count                 occupied FIFO entries
//   o_overflow_err               sticky: a word arrived while the FIFO was full
module frontend_read_return_serializer #(
  parameter int unsigned FRONTEND_WORD_SIZE = 256,
  parameter int unsigned BEATS              = 4,
  parameter int unsigned DEPTH              = 4,
  parameter int unsigned ID_WIDTH           = 4,
  parameter int unsigned CORE_NUM_WIDTH     = 2,
  parameter int unsigned CRITICAL_FIRST     = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  output logic                                  o_frontend_receive_ready,
  input  logic                                  i_returned_data_valid,
  input  logic [BEATS*FRONTEND_WORD_SIZE-1:0]   i_returned_data,
  input  logic [ID_WIDTH-1:0]                   i_returned_request_id,
  input  logic [CORE_NUM_WIDTH-1:0]             i_returned_core_num,
  input  logic [$clog2(BEATS)-1:0]              i_returned_start_beat,
  input  logic                                  i_interconnection_ready,
  output logic                                  o_scheduler_request_valid,
  output logic [FRONTEND_WORD_SIZE-1:0]         o_scheduler_read_data,
  output logic                                  o_scheduler_read_data_last,
  output logic [ID_WIDTH-1:0]                   o_scheduler_request_id,
  output logic [CORE_NUM_WIDTH-1:0]             o_scheduler_core_num,
  output logic [$clog2(BEATS)-1:0]              o_beat_index,
  output logic [$clog2(DEPTH+1)-1:0]            o_fifo_count,
  output logic                                  o_overflow_err
);

  localparam int unsigned FWS = FRONTEND_WORD_SIZE;
  localparam int unsigned WW  = BEATS * FRONTEND_WORD_SIZE;
  localparam int unsigned BW  = $clog2(BEATS);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = $clog2(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [BW-1:0]     bc;
  logic              overflow;

  logic [WW-1:0]             data_mem  [DEPTH];
  logic [ID_WIDTH-1:0]       id_mem    [DEPTH];
  logic [CORE_NUM_WIDTH-1:0] core_mem  [DEPTH];
  logic [BW-1:0]             start_mem [DEPTH];

  logic              ready;
  logic              push;
  logic              streaming;
  logic              last_beat;
  logic              pop;
  logic [BW-1:0]     beat_idx;
  logic [WW-1:0]     head_word;
  logic [FWS-1:0]    beat_sel;

  // Ready comes from the registered count only; a same-cycle pop does not free a slot.
  assign ready      = (count != CW'(DEPTH));
  assign push       = i_returned_data_valid && ready;
  assign streaming  = (state == STREAM);
  assign last_beat  = (bc == BW'(BEATS - 1));
  assign pop        = streaming && i_interconnection_ready && last_beat;
  assign count_next = count + CW'(push) - CW'(pop);

  // Beat index wraps naturally in BW bits because BEATS is a power of two.
  assign head_word = data_mem[rd_ptr];
  assign beat_idx  = start_mem[rd_ptr] + bc;

  // Select the current beat out of the head word.
  always_comb begin
    beat_sel = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_idx == BW'(k)) beat_sel = head_word[k*FWS +: FWS];
    end
  end

  // Payload storage; contents are only observed while streaming, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= i_returned_data;
      id_mem[wr_ptr]    <= i_returned_request_id;
      core_mem[wr_ptr]  <= i_returned_core_num;
      start_mem[wr_ptr] <= (CRITICAL_FIRST != 0) ? i_returned_start_beat : '0;
    end
  end

  // Control FSM: pointers, occupancy, beat counter and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bc       <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (i_returned_data_valid && !ready) overflow <= 1'b1;
      count <= count_next;
      case (state)
        IDLE: begin
          if (count_next != '0) state <= STREAM;
        end
        STREAM: begin
          if (i_interconnection_ready) begin
            if (last_beat) begin
              bc     <= '0;
              rd_ptr <= rd_ptr + PW'(1);
              if (count_next == '0) state <= IDLE;
            end else begin
              bc <= bc + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are driven purely from registered state; payload is zero while idle.
  assign o_frontend_receive_ready   = ready;
  assign o_scheduler_request_valid  = streaming;
  assign o_scheduler_read_data      = streaming ? beat_sel : '0;
  assign o_scheduler_read_data_last = streaming && last_beat;
  assign o_scheduler_request_id     = streaming ? id_mem[rd_ptr] : '0;
  assign o_scheduler_core_num       = streaming ? core_mem[rd_ptr] : '0;
  assign o_beat_index               = streaming ? beat_idx : '0;
  assign o_fifo_count               = count;
  assign o_overflow_err             = overflow;

endmodule
